decode_mux_arb: RTL and testbench
=================================

Name: decode_mux_arb

Overview:
- Parametrised successor to the third decode stage. Merges NUM_CH format-specific decoder outputs into one decoded-instruction stream.
- Each channel has a valid/ready handshake. Arbitration picks one channel per cycle; winners are buffered in a DEPTH-entry output FIFO so downstream stalls apply back-pressure to the decoders instead of dropping instructions.
- Sits between the format decoders (stage 2) and rename/dispatch.

Parameters:
- NUM_CH, 4, number of input channels (format decoders); 2..16.
- PAYLOAD_W, 256, packed decoded-instruction width: opcode, address, unit type, IDs, pid/tid, operands, imm.
- DEPTH, 4, output FIFO entries; power of two, >= 2.
- CH_W, $clog2(NUM_CH), channel index width.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clock_i  in  1  clock; all state on posedge.
- reset_i  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush; discards buffered entries.
- in_valid_i  in  NUM_CH  per-channel valid; bit c = channel c.
- in_ready_o  out  NUM_CH  per-channel ready (one-hot or zero).
- in_payload_i  in  NUM_CH*PAYLOAD_W  channel c at bits [c*PAYLOAD_W +: PAYLOAD_W].
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  downstream accepts head.
- out_payload_o  out  PAYLOAD_W  FIFO head payload.
- out_src_o  out  CH_W  channel index that produced the head.
- occupancy_o  out  CNT_W  current FIFO entry count.
- collision_o  out  1  registered pulse: more than one in_valid_i set in a cycle where a grant occurred.

Behaviour:
- Reset (reset_i=1 at posedge) clears the FIFO, pointers, occupancy and priority pointer, and sets collision_o=0. While reset is asserted, in_ready_o=0 and out_valid_o=0. Reset overrides flush and all handshakes.
- Outputs after reset: out_valid_o=0, out_payload_o=0, out_src_o=0, occupancy_o=0, collision_o=0.
- can_accept = (occupancy < DEPTH) OR (out_valid_o AND out_ready_i). Simultaneous pop on a full FIFO frees the slot in the same cycle.
- Grant (combinational): if can_accept and any in_valid_i, exactly one in_ready_o bit is set, for the arbitration winner. Otherwise in_ready_o = 0.
- Handshake: a channel transfers when in_valid_i[c] and in_ready_o[c] are both high at a posedge. The payload and index c are written at the tail.
- Latency: accept at edge N makes the entry visible at the head after edge N. When the FIFO is empty, out_valid_o rises the cycle after accept. No combinational path from in_* to out_*.
- Pop: out_valid_o and out_ready_i both high at a posedge advances the head.
- Push and pop in the same cycle: occupancy unchanged. Pointers wrap modulo DEPTH.
- Ordering: strictly FIFO; entries leave in grant order.
- out_payload_o and out_src_o hold their values while out_valid_o=1 and out_ready_i=0. When empty they hold the last popped value (don't-care, not X).
- Flush: when flush_i=1, in_ready_o=0 in that cycle and no accept occurs. At the edge, occupancy goes to 0, pointers reset, out_valid_o=0 next cycle, and the priority pointer is unchanged. Any pop in the same cycle is ignored.
- collision_o: set for one cycle after an edge where a grant occurred and popcount(in_valid_i) > 1; otherwise 0.
- Default arbitration is fixed priority: the lowest-index valid channel wins.

Optional Feature:
- Macro: DECODE_MUX_RR_EN.
- Defined: round-robin arbitration. A CH_W-bit priority pointer resets to 0. After a grant to channel c, the pointer becomes (c+1) mod NUM_CH. The search starts at the pointer and wraps. The pointer updates only on an actual transfer, never on flush or stall.
- Undefined: fixed priority as in Behaviour. No pointer register is instantiated.

Test Plan:
- Reset, then single channel: NUM_CH=4; in_valid_i=4'b0100 with payload 0xA5.., out_ready_i=1. Expect in_ready_o=4'b0100; one cycle later out_valid_o=1, out_payload_o=0xA5.., out_src_o=2, occupancy_o=1.
- Back-pressure fill: out_ready_i=0, channel 0 valid for 6 cycles, DEPTH=4. Expect four accepts, then in_ready_o=0 with occupancy_o=4. Raise out_ready_i and expect heads popped in order with continuous accepts, including a push and pop on the same edge with occupancy held at 4.
- Contention: in_valid_i=4'b1111 held, out_ready_i=1. Without the macro, expect out_src_o sequence 0,0,0,... with collision_o=1. With DECODE_MUX_RR_EN, expect 0,1,2,3,0.
- Flush mid-stream: occupancy_o=3, assert flush_i for one cycle with in_valid_i=4'b0001. Expect in_ready_o=0 that cycle, then occupancy_o=0 and out_valid_o=0. The next accept restarts cleanly at pointer 0.
- Reset mid-operation: occupancy_o=2, with a push and pop pending. Assert reset_i for one cycle. Expect all outputs at reset values on the next cycle and no ghost entry afterwards.
- Wrap-around: run 3*DEPTH+1 sequential transfers with payloads = sequence numbers. Expect out_payload_o to exactly match the input sequence with no loss or duplication.

Source files
------------

// File: rtl/decode_mux_arb.sv
// ============================================================================
// Module   : decode_mux_arb
// Brief    : Merges NUM_CH decoder channels into one FIFO-buffered stream.
//            Define DECODE_MUX_RR_EN for round-robin arbitration (default is
//            fixed priority, lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_mux_arb #(
    parameter int NUM_CH    = 4,
    parameter int PAYLOAD_W = 256,
    parameter int DEPTH     = 4,
    parameter int CH_W      = $clog2(NUM_CH),
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        flush_i,
    input  logic [NUM_CH-1:0]           in_valid_i,
    output logic [NUM_CH-1:0]           in_ready_o,
    input  logic [NUM_CH*PAYLOAD_W-1:0] in_payload_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [PAYLOAD_W-1:0]        out_payload_o,
    output logic [CH_W-1:0]             out_src_o,
    output logic [CNT_W-1:0]            occupancy_o,
    output logic                        collision_o
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [PAYLOAD_W-1:0]  payload_mem_q [DEPTH];
    logic [CH_W-1:0]       src_mem_q     [DEPTH];
    logic [c_PTR_W-1:0]    head_q;
    logic [c_PTR_W-1:0]    tail_q;
    logic [CNT_W-1:0]      count_q;
    logic [PAYLOAD_W-1:0]  last_payload_q;
    logic [CH_W-1:0]       last_src_q;
    logic                  collision_q;

    logic                  w_not_empty;
    logic                  w_pop;
    logic                  w_can_accept;
    logic                  w_found;
    logic                  w_grant;
    logic                  w_multi;
    logic [CH_W-1:0]       w_start;
    logic [CH_W-1:0]       w_sel;
    logic [CH_W:0]         w_sum;
    logic [2*NUM_CH-1:0]   w_dbl;
    logic [NUM_CH-1:0]     w_rot;
    logic [PAYLOAD_W-1:0]  w_in_payload;

`ifdef DECODE_MUX_RR_EN
    logic [CH_W-1:0]       prio_q;
    logic [CH_W-1:0]       prio_d;

    assign w_start = prio_q;
    assign prio_d  = (w_sel == CH_W'(NUM_CH - 1)) ? '0 : w_sel + 1'b1;

    // Pointer moves only on a real transfer; flush and stall leave it alone.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            prio_q <= '0;
        end else if (w_grant) begin
            prio_q <= prio_d;
        end
    end
`else
    assign w_start = '0;
`endif

    assign w_not_empty  = (count_q != '0);
    assign out_valid_o  = w_not_empty && !reset_i;
    assign w_pop        = out_valid_o && out_ready_i;
    assign w_can_accept = (count_q < CNT_W'(DEPTH)) || w_pop;
    assign w_multi      = ($countones(in_valid_i) > 1);

    // Rotate valids so the search always begins at bit 0 of w_rot.
    assign w_dbl = {in_valid_i, in_valid_i};

    always_comb begin
        w_rot   = '0;
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int k = 0; k < 2 * NUM_CH; k++) begin
            if ((k >= int'(w_start)) && (k < int'(w_start) + NUM_CH)) begin
                w_rot[k - int'(w_start)] = w_dbl[k];
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, w_start} + (CH_W+1)'(k);
                if (w_sum >= (CH_W+1)'(NUM_CH)) begin
                    w_sum = w_sum - (CH_W+1)'(NUM_CH);
                end
                w_sel = w_sum[CH_W-1:0];
            end
        end
    end

    assign w_grant    = w_found && w_can_accept && !flush_i && !reset_i;
    assign in_ready_o = w_grant ? (NUM_CH'(1) << w_sel) : '0;

    always_comb begin
        w_in_payload = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sel == CH_W'(c)) begin
                w_in_payload = in_payload_i[c*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // Storage needs no reset: a slot is only read after being written.
    always_ff @(posedge clock_i) begin
        if (w_grant) begin
            payload_mem_q[tail_q] <= w_in_payload;
            src_mem_q[tail_q]     <= w_sel;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            last_payload_q <= '0;
            last_src_q     <= '0;
            collision_q    <= 1'b0;
        end else if (flush_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            collision_q <= 1'b0;
        end else begin
            if (w_grant) begin
                tail_q <= tail_q + 1'b1;
            end
            if (w_pop) begin
                head_q         <= head_q + 1'b1;
                last_payload_q <= payload_mem_q[head_q];
                last_src_q     <= src_mem_q[head_q];
            end
            if (w_grant && !w_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!w_grant && w_pop) begin
                count_q <= count_q - 1'b1;
            end
            collision_q <= w_grant && w_multi;
        end
    end

    // When empty, present the last popped entry rather than a stale slot.
    assign out_payload_o = w_not_empty ? payload_mem_q[head_q] : last_payload_q;
    assign out_src_o     = w_not_empty ? src_mem_q[head_q]     : last_src_q;
    assign occupancy_o   = count_q;
    assign collision_o   = collision_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_mux_arb.sv
// ============================================================================
// Module   : tb_decode_mux_arb
// Brief    : Directed self-checking bench for decode_mux_arb (NUM_CH=4,
//            DEPTH=4); honours DECODE_MUX_RR_EN for the contention vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_mux_arb;

    localparam int c_NUM_CH = 4;
    localparam int c_PW     = 256;
    localparam int c_DEPTH  = 4;

    logic                       r_clock = 1'b0;
    logic                       r_reset = 1'b1;
    logic                       r_flush = 1'b0;
    logic [c_NUM_CH-1:0]        r_in_valid = '0;
    logic [c_NUM_CH*c_PW-1:0]   r_in_payload = '0;
    logic                       r_out_ready = 1'b0;
    logic [c_NUM_CH-1:0]        w_in_ready;
    logic                       w_out_valid;
    logic [c_PW-1:0]            w_out_payload;
    logic [1:0]                 w_out_src;
    logic [2:0]                 w_occupancy;
    logic                       w_collision;

    int n_vec = 0;
    int n_err = 0;

    decode_mux_arb #(
        .NUM_CH    (c_NUM_CH),
        .PAYLOAD_W (c_PW),
        .DEPTH     (c_DEPTH)
    ) u_dut (
        .clock_i       (r_clock),
        .reset_i       (r_reset),
        .flush_i       (r_flush),
        .in_valid_i    (r_in_valid),
        .in_ready_o    (w_in_ready),
        .in_payload_i  (r_in_payload),
        .out_valid_o   (w_out_valid),
        .out_ready_i   (r_out_ready),
        .out_payload_o (w_out_payload),
        .out_src_o     (w_out_src),
        .occupancy_o   (w_occupancy),
        .collision_o   (w_collision)
    );

    always #5 r_clock = ~r_clock;

    task automatic check_vec(input string tag, input logic [c_PW-1:0] obs,
                             input logic [c_PW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clock);
        #1;
    endtask

    task automatic set_pl(input int ch, input logic [c_PW-1:0] val);
        r_in_payload[ch*c_PW +: c_PW] = val;
    endtask

    logic [c_PW-1:0] q_exp[$];
    logic [c_PW-1:0] v_a5;
    int              sent;
    int              cyc;
    logic            exp_rdy;

    initial begin
        v_a5 = {32{8'hA5}};

        // Reset: ready and valid held low even with all channels requesting.
        r_in_valid = 4'b1111;
        tick();
        check_vec("rst_ready", c_PW'(w_in_ready), '0);
        check_vec("rst_valid", c_PW'(w_out_valid), '0);
        check_vec("rst_payload", w_out_payload, '0);
        check_vec("rst_src", c_PW'(w_out_src), '0);
        check_vec("rst_occ", c_PW'(w_occupancy), '0);
        check_vec("rst_coll", c_PW'(w_collision), '0);
        r_in_valid = '0;
        r_reset    = 1'b0;
        tick();

        // Single channel.
        r_in_valid  = 4'b0100;
        set_pl(2, v_a5);
        r_out_ready = 1'b1;
        #1;
        check_vec("single_ready", c_PW'(w_in_ready), c_PW'(4'b0100));
        tick();
        r_in_valid = '0;
        check_vec("single_valid", c_PW'(w_out_valid), 1);
        check_vec("single_payload", w_out_payload, v_a5);
        check_vec("single_src", c_PW'(w_out_src), 2);
        check_vec("single_occ", c_PW'(w_occupancy), 1);
        tick();
        check_vec("single_drained", c_PW'(w_occupancy), 0);
        check_vec("single_hold", w_out_payload, v_a5);

        // Back-pressure fill.
        r_out_ready = 1'b0;
        r_in_valid  = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            set_pl(0, c_PW'(i + 1));
            #1;
            check_vec("fill_ready", c_PW'(w_in_ready), (i < 4) ? c_PW'(1) : '0);
            tick();
        end
        check_vec("fill_occ", c_PW'(w_occupancy), 4);
        check_vec("fill_head", w_out_payload, c_PW'(1));
        set_pl(0, c_PW'(100));
        r_out_ready = 1'b1;
        #1;
        check_vec("full_pop_ready", c_PW'(w_in_ready), c_PW'(1));
        tick();
        check_vec("pushpop_occ", c_PW'(w_occupancy), 4);
        r_in_valid = '0;
        begin
            int exp_seq[4] = '{2, 3, 4, 100};
            for (int k = 0; k < 4; k++) begin
                check_vec("drain_valid", c_PW'(w_out_valid), 1);
                check_vec("drain_head", w_out_payload, c_PW'(exp_seq[k]));
                tick();
            end
        end
        check_vec("drain_occ", c_PW'(w_occupancy), 0);

        // Contention from a clean priority pointer.
        r_reset = 1'b1;
        tick();
        r_reset = 1'b0;
        for (int c = 0; c < 4; c++) set_pl(c, c_PW'(16 + c));
        r_in_valid  = 4'b1111;
        r_out_ready = 1'b1;
        begin
`ifdef DECODE_MUX_RR_EN
            int exp_src[5] = '{0, 1, 2, 3, 0};
`else
            int exp_src[5] = '{0, 0, 0, 0, 0};
`endif
            for (int k = 0; k < 5; k++) begin
                tick();
                check_vec("cont_src", c_PW'(w_out_src), c_PW'(exp_src[k]));
                check_vec("cont_payload", w_out_payload, c_PW'(16 + exp_src[k]));
                check_vec("cont_coll", c_PW'(w_collision), 1);
            end
        end
        r_in_valid = '0;
        tick();
        check_vec("cont_coll_end", c_PW'(w_collision), 0);
        check_vec("cont_occ_end", c_PW'(w_occupancy), 0);

        // Flush mid-stream.
        r_out_ready = 1'b0;
        r_in_valid  = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            set_pl(0, c_PW'(50 + i));
            tick();
        end
        check_vec("flush_pre_occ", c_PW'(w_occupancy), 3);
        r_flush     = 1'b1;
        r_out_ready = 1'b1;
        #1;
        check_vec("flush_ready", c_PW'(w_in_ready), '0);
        tick();
        r_flush     = 1'b0;
        r_in_valid  = '0;
        r_out_ready = 1'b0;
        check_vec("flush_occ", c_PW'(w_occupancy), 0);
        check_vec("flush_valid", c_PW'(w_out_valid), 0);
        r_in_valid = 4'b0001;
        set_pl(0, c_PW'(77));
        tick();
        r_in_valid = '0;
        check_vec("flush_restart_occ", c_PW'(w_occupancy), 1);
        check_vec("flush_restart_head", w_out_payload, c_PW'(77));
        check_vec("flush_restart_src", c_PW'(w_out_src), 0);
        r_out_ready = 1'b1;
        tick();

        // Reset mid-operation with push and pop pending.
        r_out_ready = 1'b0;
        r_in_valid  = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            set_pl(1, c_PW'(60 + i));
            tick();
        end
        check_vec("mrst_pre_occ", c_PW'(w_occupancy), 2);
        set_pl(1, c_PW'(62));
        r_out_ready = 1'b1;
        r_reset     = 1'b1;
        #1;
        check_vec("mrst_ready", c_PW'(w_in_ready), '0);
        check_vec("mrst_valid_during", c_PW'(w_out_valid), 0);
        tick();
        r_reset    = 1'b0;
        r_in_valid = '0;
        check_vec("mrst_valid", c_PW'(w_out_valid), 0);
        check_vec("mrst_occ", c_PW'(w_occupancy), 0);
        check_vec("mrst_payload", w_out_payload, '0);
        check_vec("mrst_src", c_PW'(w_out_src), 0);
        check_vec("mrst_coll", c_PW'(w_collision), 0);
        tick();
        check_vec("mrst_noghost_valid", c_PW'(w_out_valid), 0);
        check_vec("mrst_noghost_occ", c_PW'(w_occupancy), 0);

        // Wrap-around with irregular downstream stalls, scoreboarded.
        sent = 0;
        cyc  = 0;
        while ((sent < 3 * c_DEPTH + 1 || q_exp.size() > 0) && cyc < 200) begin
            r_out_ready = (cyc % 3 != 0);
            r_in_valid  = (sent < 3 * c_DEPTH + 1) ? 4'b1000 : 4'b0000;
            set_pl(3, c_PW'(300 + sent));
            #1;
            exp_rdy = (sent < 3 * c_DEPTH + 1) &&
                      ((q_exp.size() < c_DEPTH) || (q_exp.size() > 0 && r_out_ready));
            check_vec("wrap_ready", c_PW'(w_in_ready), exp_rdy ? c_PW'(4'b1000) : '0);
            check_vec("wrap_occ", c_PW'(w_occupancy), c_PW'(q_exp.size()));
            check_vec("wrap_valid", c_PW'(w_out_valid), c_PW'(q_exp.size() > 0));
            if (q_exp.size() > 0) begin
                check_vec("wrap_payload", w_out_payload, q_exp[0]);
                if (r_out_ready) void'(q_exp.pop_front());
            end
            if (exp_rdy) begin
                q_exp.push_back(c_PW'(300 + sent));
                sent++;
            end
            tick();
            cyc++;
        end
        check_vec("wrap_done", c_PW'(sent == 3 * c_DEPTH + 1 && q_exp.size() == 0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
